dsc_mul_seq: RTL and testbench
==============================

Name: dsc_mul_seq

Overview:
- Run sequencer and result buffer wrapped around the 4-input deterministic stochastic multiplier core.
- Accepts one operand set (a,b,c,d) through a valid/ready handshake, then clears and enables the core.
- Detects end of run on the core's ov flag (early shutoff) or on a watchdog, and captures the core's z count.
- Presents the product and the run length downstream through a valid/ready handshake.
- Sits between the operand source and the core; it consumes z and ov.

Parameters:
- SNG_WIDTH, 8: operand width per input.
- NUM_INPUTS, 4: number of operands; fixed at 4 in this block.
- Z_WIDTH, NUM_INPUTS*SNG_WIDTH (32): core count and result width.
- CYC_WIDTH, Z_WIDTH+1 (33): run-cycle counter width. Holds a full 2^32-cycle run.
- WDOG_LIMIT, 2^32+8: RUN cycle count at which the watchdog forces termination.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept an operand set.
- a, b, c, d  in  SNG_WIDTH each  operands (unsigned fractions x/2^SNG_WIDTH).
- core_a, core_b, core_c, core_d  out  SNG_WIDTH each  latched operands driven to the core.
- core_rst  out  1  core reset pulse.
- core_en  out  1  core enable.
- core_z  in  Z_WIDTH  core output count.
- core_ov  in  1  core done/early-shutoff flag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_z  out  Z_WIDTH  product count (a*b*c*d / 2^Z_WIDTH as a fraction).
- out_cycles  out  CYC_WIDTH  number of RUN cycles spent.
- out_timeout  out  1  run was ended by the watchdog.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) has priority everywhere:
  - State goes to IDLE.
  - in_ready=1.
  - out_valid=0, out_z=0, out_cycles=0, out_timeout=0.
  - core_en=0, core_rst=1. core_rst is registered; it stays high during reset and for the cycle after reset deasserts.
  - Operand registers cleared to 0.
- Reset mid-run or mid-hold aborts immediately. The pending result is lost. No output handshake occurs.
- States: IDLE, CLR, RUN, DRAIN, HOLD.
- IDLE:
  - in_ready=1, core_en=0, core_rst=0.
  - On in_valid&in_ready: latch a..d into core_a..d, clear the cycle counter and out_timeout.
  - If any operand is 0: go directly to HOLD with out_z=0, out_cycles=0. No core activity.
  - Otherwise go to CLR.
- CLR, one cycle: core_rst=1, core_en=0, in_ready=0. Then go to RUN.
- RUN:
  - core_en=1; the cycle counter increments each cycle.
  - core_ov is ignored in the first RUN cycle, which is core pipeline settle.
  - From the second RUN cycle, core_ov=1 moves to DRAIN.
  - If the counter equals WDOG_LIMIT-1 and core_ov=0: move to DRAIN and set out_timeout=1.
  - If both conditions hold in the same cycle, core_ov wins and out_timeout stays 0.
- DRAIN, one cycle:
  - core_en=0 so the core counter's final increment lands.
  - Next edge: out_z<=core_z, out_cycles<=counter; go to HOLD.
- HOLD:
  - out_valid=1; out_z, out_cycles and out_timeout are stable. in_ready=0.
  - On out_ready=1: out_valid falls next cycle and state goes to IDLE.
  - A new operand set can be accepted the cycle after return to IDLE. There is no same-cycle bypass, so at most 1 result is in flight.
- Operand registers stay stable from CLR through HOLD. core_a..d never change during RUN.
- The core counter is never read while core_en=1.
- Latency, nonzero operands: accept edge -> CLR (1) -> RUN (N) -> DRAIN (1) -> out_valid. out_valid rises N+3 cycles after the accepting edge.
- Latency, zero operand: out_valid rises 1 cycle after the accepting edge.
- All arithmetic is unsigned. The counter saturates at WDOG_LIMIT and never wraps.
- in_valid held high while busy: ignored and not consumed.

Test Plan:
- Bench drives a behavioural core stub with a programmable ov delay and z value.
- Reset: hold rst 3 cycles -> in_ready=1, out_valid=0, core_rst=1 through the cycle after release, core_en=0.
- a=b=c=d=0x80, stub asserts ov after 5 RUN cycles with z=0x10000000 -> core_rst pulse 1 cycle, core_en high 5 cycles then low 1 cycle, out_z=0x10000000, out_cycles=5, out_timeout=0, out_valid at +8 cycles.
- b=0x00 -> no core_rst/core_en activity, out_valid after 1 cycle, out_z=0, out_cycles=0.
- Stub holds ov=1 from the first RUN cycle -> ov ignored in cycle 1, exit after cycle 2, out_cycles=2.
- Bench sets WDOG_LIMIT=16 and the stub never asserts ov -> exit at count 16, out_timeout=1. A separate case with ov=1 exactly at count 15 -> out_timeout=0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 -> IDLE and the next operand set is accepted one cycle later.
- rst asserted mid-RUN -> IDLE next cycle, no out_valid, core_en=0.

Source files
------------

// File: rtl/dsc_mul_seq.sv
// Run sequencer and result buffer around the 4-input deterministic stochastic multiplier core.
// Latches one operand set, runs the core until ov or watchdog, then holds the product for downstream.
module dsc_mul_seq #(
  parameter int SNG_WIDTH  = 8,
  parameter int NUM_INPUTS = 4,
  parameter int Z_WIDTH    = NUM_INPUTS * SNG_WIDTH,
  parameter int CYC_WIDTH  = Z_WIDTH + 1,
  parameter logic [CYC_WIDTH-1:0] WDOG_LIMIT = (CYC_WIDTH'(1) << Z_WIDTH) + CYC_WIDTH'(8)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] a,
  input  logic [SNG_WIDTH-1:0] b,
  input  logic [SNG_WIDTH-1:0] c,
  input  logic [SNG_WIDTH-1:0] d,
  output logic [SNG_WIDTH-1:0] core_a,
  output logic [SNG_WIDTH-1:0] core_b,
  output logic [SNG_WIDTH-1:0] core_c,
  output logic [SNG_WIDTH-1:0] core_d,
  output logic                 core_rst,
  output logic                 core_en,
  input  logic [Z_WIDTH-1:0]   core_z,
  input  logic                 core_ov,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Z_WIDTH-1:0]   out_z,
  output logic [CYC_WIDTH-1:0] out_cycles,
  output logic                 out_timeout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

  localparam logic [CYC_WIDTH-1:0] WDOG_LAST = WDOG_LIMIT - CYC_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0] CYC_ZERO  = {CYC_WIDTH{1'b0}};

  // A zero operand forces a zero product, so the core run can be skipped entirely.
  function automatic logic any_zero(
    input logic [SNG_WIDTH-1:0] op_a,
    input logic [SNG_WIDTH-1:0] op_b,
    input logic [SNG_WIDTH-1:0] op_c,
    input logic [SNG_WIDTH-1:0] op_d
  );
    return (op_a == {SNG_WIDTH{1'b0}}) || (op_b == {SNG_WIDTH{1'b0}}) ||
           (op_c == {SNG_WIDTH{1'b0}}) || (op_d == {SNG_WIDTH{1'b0}});
  endfunction

  state_t               state_r;
  logic [CYC_WIDTH-1:0] cyc_cnt_r;
  logic                 accept_s;
  logic                 zero_op_s;
  logic                 ov_exit_s;
  logic                 wdog_hit_s;

  assign accept_s   = (state_r == IDLE) && in_ready && in_valid;
  assign zero_op_s  = any_zero(a, b, c, d);
  // The counter is still zero in the first RUN cycle, while the core pipeline settles.
  assign ov_exit_s  = core_ov && (cyc_cnt_r != CYC_ZERO);
  assign wdog_hit_s = (cyc_cnt_r == WDOG_LAST);

  // Sequencer FSM with registered handshake, core control and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cyc_cnt_r   <= CYC_ZERO;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_z       <= {Z_WIDTH{1'b0}};
      out_cycles  <= CYC_ZERO;
      out_timeout <= 1'b0;
      core_en     <= 1'b0;
      core_rst    <= 1'b1;
      core_a      <= {SNG_WIDTH{1'b0}};
      core_b      <= {SNG_WIDTH{1'b0}};
      core_c      <= {SNG_WIDTH{1'b0}};
      core_d      <= {SNG_WIDTH{1'b0}};
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          core_rst <= 1'b0;
          core_en  <= 1'b0;
          if (accept_s) begin
            core_a      <= a;
            core_b      <= b;
            core_c      <= c;
            core_d      <= d;
            cyc_cnt_r   <= CYC_ZERO;
            out_timeout <= 1'b0;
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            if (zero_op_s) begin
              out_z      <= {Z_WIDTH{1'b0}};
              out_cycles <= CYC_ZERO;
              out_valid  <= 1'b1;
              state_r    <= HOLD;
            end else begin
              core_rst <= 1'b1;
              state_r  <= CLR;
            end
          end
        end
        CLR: begin
          core_rst <= 1'b0;
          core_en  <= 1'b1;
          state_r  <= RUN;
        end
        RUN: begin
          if (cyc_cnt_r != WDOG_LIMIT) begin
            cyc_cnt_r <= cyc_cnt_r + CYC_WIDTH'(1);
          end
          if (ov_exit_s || wdog_hit_s) begin
            core_en     <= 1'b0;
            out_timeout <= !ov_exit_s;
            state_r     <= DRAIN;
          end
        end
        DRAIN: begin
          // core_en dropped a cycle ago, so core_z now includes the final increment.
          out_z      <= core_z;
          out_cycles <= cyc_cnt_r;
          out_valid  <= 1'b1;
          state_r    <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          core_en   <= 1'b0;
          core_rst  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Directed bench for dsc_mul_seq: vector table plus hand-written backpressure and mid-run reset sequences.
// A behavioural core stub raises ov a programmable number of enabled cycles after its reset.
module tb_dsc_mul_seq;
  localparam int SW = 8;
  localparam int ZW = 32;
  localparam int CW = 33;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] a, b, c, d;
  logic [SW-1:0] core_a, core_b, core_c, core_d;
  logic          core_rst;
  logic          core_en;
  logic [ZW-1:0] core_z;
  logic          core_ov;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] out_z;
  logic [CW-1:0] out_cycles;
  logic          out_timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;

  dsc_mul_seq #(
    .SNG_WIDTH(SW), .NUM_INPUTS(4), .Z_WIDTH(ZW), .CYC_WIDTH(CW), .WDOG_LIMIT(33'd16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_rst(core_rst), .core_en(core_en), .core_z(core_z), .core_ov(core_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_cycles(out_cycles), .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core stub: counts enabled cycles since its reset, ov once the count reaches ov_delay.
  int unsigned   ov_delay = 32'd1000;
  logic [ZW-1:0] stub_z   = 32'h0;
  int unsigned   en_cnt;
  always @(posedge clk) begin
    if (core_rst) en_cnt <= 0;
    else if (core_en) en_cnt <= en_cnt + 1;
  end
  assign core_ov = core_en && ((en_cnt + 1) >= ov_delay);
  assign core_z  = stub_z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  a, b, c, d;
    int unsigned ov_delay;
    logic [31:0] z;
    logic [31:0] exp_z;
    logic [32:0] exp_cyc;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  // Wait until the sequencer is idle, hand over one set, and return right after the accepting edge.
  task automatic send(input logic [7:0] va, vb, vc, vd);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    a = va; b = vb; c = vc; d = vd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, en_n, rst_cnt;
    bit got;
    ov_delay = v.ov_delay;
    stub_z   = v.z;
    send(v.a, v.b, v.c, v.d);
    check({tag, "_busy"}, busy, 1'b1);
    lat = 1; en_n = 0; rst_cnt = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (core_en) en_n++;
      if (core_rst) rst_cnt++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_valid_seen"}, got, 1'b1);
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_out_z"}, out_z, v.exp_z);
    check({tag, "_out_cycles"}, out_cycles, v.exp_cyc);
    check({tag, "_out_timeout"}, out_timeout, v.exp_to);
    check({tag, "_core_ops"}, {core_a, core_b, core_c, core_d}, {v.a, v.b, v.c, v.d});
    check({tag, "_en_cycles"}, en_n, v.exp_cyc);
    check({tag, "_rst_cycles"}, rst_cnt, (v.exp_cyc != 33'd0) ? 1 : 0);
    take_result(tag);
  endtask

  initial begin
    bit seen;
    vecs[0] = '{8'h80, 8'h80, 8'h80, 8'h80, 5,    32'h1000_0000, 32'h1000_0000, 33'd5,  1'b0, 8};
    vecs[1] = '{8'h12, 8'h00, 8'h34, 8'h56, 5,    32'h0000_DEAD, 32'h0000_0000, 33'd0,  1'b0, 1};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1,    32'h1234_5678, 32'h1234_5678, 33'd2,  1'b0, 5};
    vecs[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 1000, 32'h0000_AAAA, 32'h0000_AAAA, 33'd16, 1'b1, 19};
    vecs[4] = '{8'h40, 8'h80, 8'hC0, 8'hFF, 16,   32'h0000_5555, 32'h0000_5555, 33'd16, 1'b0, 19};
    vecs[5] = '{8'h00, 8'h11, 8'h22, 8'h33, 1,    32'hFFFF_FFFF, 32'h0000_0000, 33'd0,  1'b0, 1};
    vecs[6] = '{8'h10, 8'h20, 8'h30, 8'h40, 3,    32'h00AB_CDEF, 32'h00AB_CDEF, 33'd3,  1'b0, 6};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h0; b = 8'h0; c = 8'h0; d = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_core_rst", core_rst, 1'b1);
    check("rst_core_en", core_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_outputs", {out_z, out_cycles, out_timeout}, 66'h0);
    check("rst_ops", {core_a, core_b, core_c, core_d}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_release_core_rst_held", core_rst, 1'b1);
    @(posedge clk);
    #1;
    check("rst_release_core_rst_low", core_rst, 1'b0);
    check("rst_release_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held while a new set waits, accepted one cycle after IDLE.
    ov_delay = 5; stub_z = 32'h1000_0000;
    send(8'h80, 8'h80, 8'h80, 8'h80);
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid_seen", out_valid, 1'b1);
    @(negedge clk);
    a = 8'h11; b = 8'h22; c = 8'h00; d = 8'h44;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i), {in_ready, out_valid, out_z, out_cycles, core_a, core_b, core_c, core_d},
            {1'b0, 1'b1, 32'h1000_0000, 33'd5, 32'h8080_8080});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready, busy}, 3'b010);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accept", {in_ready, busy, core_a, core_b, core_c, core_d}, {1'b0, 1'b1, 32'h1122_0044});
    check("bp_next_zero_result", {out_valid, out_z, out_cycles}, {1'b1, 32'h0, 33'd0});
    take_result("bp_next");

    // Reset in the middle of a run aborts it with no result.
    ov_delay = 1000; stub_z = 32'h0BAD_0BAD;
    send(8'h33, 8'h44, 8'h55, 8'h66);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_running", core_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_state", {busy, in_ready, core_en, out_valid, core_rst}, 5'b01001);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || core_en) seen = 1'b1;
    end
    check("midrst_no_result", seen, 1'b0);
    run_vec(vecs[6], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "bench did not complete");
  end
endmodule
